// File: rtl/servo_pwm_driver.sv
// Hobby-servo PWM generator: fixed frame period, pulse width linear in an 8-bit
// position that is slew-limited once per frame toward the sampled target.
module servo_pwm_driver #(
    parameter int unsigned CLK_HZ    = 12000000,
    parameter int unsigned PERIOD_US = 20000,
    parameter int unsigned MIN_US    = 1000,
    parameter int unsigned MAX_US    = 2000,
    parameter int unsigned STEP      = 4,
    parameter int unsigned INI       = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] target,
    output logic       pwm,
    output logic       frame_tick,
    output logic [7:0] pos,
    output logic       at_target
);

    localparam int unsigned DIV  = CLK_HZ / 1000000;
    localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned UW   = $clog2(PERIOD_US);
    localparam int unsigned SPAN = MAX_US - MIN_US;
    localparam int unsigned MW   = 8 + $clog2(SPAN) + 1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t          state;
    logic [PW-1:0]   pre;
    logic [UW-1:0]   us_cnt;
    logic [UW-1:0]   width_us;
    logic            en_f;

    logic            us_tick;
    logic            frame_end;
    logic [8:0]      pos9;
    logic [8:0]      tgt9;
    logic [8:0]      up9;
    logic [8:0]      dn9;
    logic [7:0]      pos_next;
    logic [MW-1:0]   prod;
    logic [UW-1:0]   width_next;

    always_comb begin
        us_tick   = (pre == PW'(DIV - 1));
        frame_end = us_tick && (us_cnt == UW'(PERIOD_US - 1));
        pos9      = {1'b0, pos};
        tgt9      = {1'b0, target};
        up9       = pos9 + 9'(STEP);
        dn9       = tgt9 + 9'(STEP);
        pos_next  = pos;
        // 9-bit compares clamp at the target instead of wrapping past 0/255
        if (pos < target) begin
            pos_next = (up9 > tgt9) ? target : up9[7:0];
        end else if (pos > target) begin
            pos_next = (pos9 < dn9) ? target : 8'(pos9 - 9'(STEP));
        end
        prod       = MW'(pos_next) * MW'(SPAN);
        width_next = UW'(MIN_US) + UW'(prod >> 8);
    end

    // ST_IDLE spends the release cycle so the first frame_tick lands on a
    // clean (0,0) counter state with frame_tick visible in its own cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pre        <= '0;
            us_cnt     <= '0;
            width_us   <= '0;
            en_f       <= 1'b0;
            frame_tick <= 1'b0;
            pwm        <= 1'b0;
            pos        <= 8'(INI);
            at_target  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state      <= ST_RUN;
                    frame_tick <= 1'b1;
                end
                ST_RUN: begin
                    pre <= us_tick ? '0 : pre + PW'(1);
                    if (us_tick) begin
                        us_cnt <= (us_cnt == UW'(PERIOD_US - 1)) ? '0 : us_cnt + UW'(1);
                    end
                    frame_tick <= frame_end;
                    if (frame_tick) begin
                        en_f      <= en;
                        pos       <= pos_next;
                        width_us  <= width_next;
                        at_target <= (pos_next == target);
                        pwm       <= en;
                    end else begin
                        pwm <= en_f && (us_cnt < width_us);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Scoreboarded bench for servo_pwm_driver: per-frame expectations from a
// plain-arithmetic model, checked by an independent frame monitor.
module tb_servo_pwm_driver;

    localparam int CLK_HZ    = 4000000;
    localparam int PERIOD_US = 100;
    localparam int MIN_US    = 10;
    localparam int MAX_US    = 20;
    localparam int STEP      = 4;
    localparam int INI       = 128;
    localparam int DIV       = CLK_HZ / 1000000;
    localparam int FRAME     = PERIOD_US * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] target = 8'd0;
    logic       pwm;
    logic       frame_tick;
    logic [7:0] pos;
    logic       at_target;

    servo_pwm_driver #(
        .CLK_HZ    (CLK_HZ),
        .PERIOD_US (PERIOD_US),
        .MIN_US    (MIN_US),
        .MAX_US    (MAX_US),
        .STEP      (STEP),
        .INI       (INI)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .target     (target),
        .pwm        (pwm),
        .frame_tick (frame_tick),
        .pos        (pos),
        .at_target  (at_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pos;
        int at;
        int high;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   mpos;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    bit active = 1'b0;
    int k, high, first, last, cap_pos, cap_at;
    int fcount = 0;

    task finish_frame();
        exp_t e;
        fcount++;
        check($sformatf("frame_len f%0d", fcount), k + 1, FRAME);
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL sb_underflow f%0d: got frame with no expectation", fcount);
        end else begin
            e = sb.pop_front();
            check($sformatf("pos f%0d", fcount), cap_pos, e.pos);
            check($sformatf("at_target f%0d", fcount), cap_at, e.at);
            check($sformatf("pwm_high f%0d", fcount), high, e.high);
            if (e.high > 0) begin
                check($sformatf("pwm_rise f%0d", fcount), first, 1);
                check($sformatf("pwm_fall f%0d", fcount), last, e.high);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            active = 1'b0;
        end else begin
            if (frame_tick) begin
                if (active) finish_frame();
                active = 1'b1;
                k = 0; high = 0; first = -1; last = -1;
            end else begin
                k++;
            end
            if (active) begin
                if (k == 1) begin
                    cap_pos = int'(pos);
                    cap_at  = int'(at_target);
                end
                if (pwm) begin
                    if (first < 0) first = k;
                    last = k;
                    high++;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int slew(input int p, input int t);
        if (p < t) return (p + STEP > t) ? t : p + STEP;
        if (p > t) return (p - STEP < t) ? t : p - STEP;
        return p;
    endfunction

    // ---------------- stimulus ----------------
    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!frame_tick && cyc < FRAME + 50);
        if (!frame_tick) begin
            n_vec++;
            n_bad++;
            $display("FAIL tick_timeout: got no frame_tick in %0d cycles", cyc);
        end
    endtask

    task automatic start_frame(input bit e, input int t);
        exp_t x;
        en     = e;
        target = 8'(t);
        mpos   = slew(mpos, t);
        x.pos  = mpos;
        x.at   = (mpos == t) ? 1 : 0;
        x.high = e ? (MIN_US + (mpos * (MAX_US - MIN_US)) / 256) * DIV : 0;
        sb.push_back(x);
    endtask

    task automatic do_frame(input bit e, input int t, input int mid_k,
                            input bit mid_e, input int mid_t);
        int c;
        wait_tick(c);
        start_frame(e, t);
        if (mid_k > 0) begin
            repeat (mid_k) @(negedge clk);
            en     = mid_e;
            target = 8'(mid_t);
        end
    endtask

    initial begin
        int c;
        mpos = INI;
        en = 1'b1;
        target = 8'd128;
        repeat (3) @(negedge clk);
        check("rst_pwm", int'(pwm), 0);
        check("rst_frame_tick", int'(frame_tick), 0);
        check("rst_pos", int'(pos), INI);
        check("rst_at_target", int'(at_target), 0);

        rst = 1'b0;
        wait_tick(c);
        check("first_tick_delay", c, 1);
        start_frame(1'b1, 128);
        repeat (2) do_frame(1'b1, 128, 0, 1'b0, 0);

        repeat (32) do_frame(1'b1, 255, 0, 1'b0, 0);
        for (int i = 0; i < 100 && mpos != 2; i++) do_frame(1'b1, 2, 0, 1'b0, 0);
        do_frame(1'b1, 0, 0, 1'b0, 0);
        do_frame(1'b1, 0, 21, 1'b0, 0);
        do_frame(1'b0, 0, 0, 1'b0, 0);
        do_frame(1'b0, 0, 100, 1'b1, 0);
        do_frame(1'b1, 0, 50, 1'b1, 200);
        do_frame(1'b1, 200, 0, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            bit e;
            int mk;
            e  = ($urandom_range(0, 3) != 0);
            mk = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 350)) : 0;
            do_frame(e, int'($urandom_range(0, 255)), mk,
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
        end

        do_frame(1'b1, 128, 31, 1'b1, 128);
        check("pwm_before_rst", int'(pwm), 1);
        rst = 1'b1;
        #1;
        check("midpulse_rst_pwm", int'(pwm), 0);
        check("midpulse_rst_pos", int'(pos), INI);
        check("midpulse_rst_at_target", int'(at_target), 0);
        check("midpulse_rst_frame_tick", int'(frame_tick), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        mpos = INI;
        wait_tick(c);
        check("tick_after_release", c, 1);
        start_frame(1'b1, 128);
        do_frame(1'b1, 128, 0, 1'b0, 0);
        wait_tick(c);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
